pro_runctl: RTL and testbench

Parametrised program-load and run controller for the Processor-Z core. It holds the instruction memory and accepts host writes while the core is idle. On `working` it issues instructions to the core one fetch per cycle, with back-pressure, until a halt opcode or a cycle watchdog ends the run. It then drains the pipeline and sequences a register-dump ID so the host can read every architectural register without any external counter.

---
 rtl/pro_runctl.sv | 201 ++++++++++++++++++++
 tb/tb_pro_runctl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pro_runctl.sv
// pro_runctl: program-load and run controller for the Processor-Z core.
// Holds instruction memory loaded by the host while idle, issues one fetch per
// cycle under back-pressure until a halt opcode or the watchdog ends the run,
// drains the pipeline, then sequences a register-dump ID for the host.
//
// Ports:
//   clock, resetn          clock and asynchronous active-low reset
//   addr, wr, wdata        host write port (accepted in IDLE/DONE only)
//   working                level request to start/hold a run
//   stall                  core back-pressure
//   instr, instr_valid     registered instruction to the core
//   pc                     address of the next fetch
//   running                high in RUN and DRAIN
//   done, timeout          run completion and watchdog flag
//   rID, dump_valid        register-dump index to the core's debug port
//   cycles                 RUN cycle count of the current/last run
//   load_err               one-cycle pulse when a host write is rejected
module pro_runctl #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 5,
  parameter int unsigned NREG       = 8,
  parameter int unsigned ID_W       = 4,
  parameter logic [3:0]  HALT_ICODE = 4'h0,
  parameter int unsigned DRAIN_CYC  = 4,
  parameter int unsigned MAX_CYCLES = 1024
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic [ADDR_W-1:0] addr,
  input  logic              wr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              working,
  input  logic              stall,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] pc,
  output logic              running,
  output logic              done,
  output logic              timeout,
  output logic [ID_W-1:0]   rID,
  output logic              dump_valid,
  output logic [15:0]       cycles,
  output logic              load_err
);

  localparam int unsigned DEPTH   = 2 ** ADDR_W;
  localparam int unsigned DCNT_W  = $clog2(DRAIN_CYC + 1);
  localparam logic [15:0] WDOG_LAST = 16'(MAX_CYCLES - 1);
  localparam logic [ID_W-1:0]   RID_LAST  = ID_W'(NREG - 1);
  localparam logic [DCNT_W-1:0] DRAIN_LAST = DCNT_W'(DRAIN_CYC);

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN, S_DUMP, S_DONE} state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   instr_q, instr_d;
  logic                instr_valid_q, instr_valid_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic                running_q, running_d;
  logic                done_q, done_d;
  logic                timeout_q, timeout_d;
  logic [ID_W-1:0]     rid_q, rid_d;
  logic                dump_valid_q, dump_valid_d;
  logic [15:0]         cycles_q, cycles_d;
  logic                load_err_q, load_err_d;
  logic [DCNT_W-1:0]   drain_q, drain_d;

  logic [DATA_W-1:0]   mem [DEPTH];
  logic [DATA_W-1:0]   fetch_word;
  logic                is_halt;
  logic                mem_we;
  logic [15:0]         cyc_inc;

  assign fetch_word = mem[pc_q];
  assign is_halt    = (fetch_word[DATA_W-1 -: 4] == HALT_ICODE);
  assign mem_we     = wr && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign cyc_inc    = cycles_q + 16'd1;

  // Instruction memory: no reset, contents survive a controller reset.
  always_ff @(posedge clock) begin
    if (mem_we) mem[addr] <= wdata;
  end

  // State and output registers.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q       <= S_IDLE;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      pc_q          <= '0;
      running_q     <= 1'b0;
      done_q        <= 1'b0;
      timeout_q     <= 1'b0;
      rid_q         <= '1;
      dump_valid_q  <= 1'b0;
      cycles_q      <= '0;
      load_err_q    <= 1'b0;
      drain_q       <= '0;
    end else begin
      state_q       <= state_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      pc_q          <= pc_d;
      running_q     <= running_d;
      done_q        <= done_d;
      timeout_q     <= timeout_d;
      rid_q         <= rid_d;
      dump_valid_q  <= dump_valid_d;
      cycles_q      <= cycles_d;
      load_err_q    <= load_err_d;
      drain_q       <= drain_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d       = state_q;
    instr_d       = instr_q;
    instr_valid_d = 1'b0;
    pc_d          = pc_q;
    done_d        = done_q;
    timeout_d     = timeout_q;
    rid_d         = rid_q;
    dump_valid_d  = 1'b0;
    cycles_d      = cycles_q;
    drain_d       = drain_q;
    load_err_d    = wr && !mem_we;

    case (state_q)
      S_IDLE: begin
        if (working && !wr) begin
          state_d   = S_RUN;
          pc_d      = '0;
          cycles_d  = '0;
          done_d    = 1'b0;
          timeout_d = 1'b0;
        end
      end
      S_RUN: begin
        if (!working) begin
          state_d = S_IDLE;
        end else begin
          cycles_d = cyc_inc;
          if (!stall) begin
            instr_d       = fetch_word;
            instr_valid_d = 1'b1;
            pc_d          = pc_q + ADDR_W'(1);
          end
          // A halt fetched on the watchdog edge wins, leaving timeout clear.
          if (!stall && is_halt) begin
            state_d = S_DRAIN;
            drain_d = '0;
          end else if (cyc_inc == WDOG_LAST) begin
            state_d   = S_DRAIN;
            drain_d   = '0;
            timeout_d = 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (!working) begin
          state_d = S_IDLE;
        end else if (drain_q == DRAIN_LAST) begin
          state_d      = S_DUMP;
          rid_d        = '0;
          dump_valid_d = 1'b1;
        end else begin
          drain_d = drain_q + DCNT_W'(1);
        end
      end
      S_DUMP: begin
        if (rid_q == RID_LAST) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          rid_d   = '1;
        end else begin
          rid_d        = rid_q + ID_W'(1);
          dump_valid_d = 1'b1;
        end
      end
      S_DONE: begin
        done_d = 1'b1;
        if (!working) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    running_d = (state_d == S_RUN) || (state_d == S_DRAIN);
  end

  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;
  assign pc          = pc_q;
  assign running     = running_q;
  assign done        = done_q;
  assign timeout     = timeout_q;
  assign rID         = rid_q;
  assign dump_valid  = dump_valid_q;
  assign cycles      = cycles_q;
  assign load_err    = load_err_q;

endmodule

// File: tb/tb_pro_runctl.sv
// Directed bench for pro_runctl: program load, halted run with dump, stalls,
// rejected writes, abort, watchdog with pc wrap, halt on the watchdog edge and
// reset mid-dump.
module tb_pro_runctl;

  logic        clock = 1'b0;
  logic        resetn;
  logic [4:0]  addr;
  logic        wr;
  logic [31:0] wdata;
  logic        working;
  logic        stall;
  logic [31:0] instr;
  logic        instr_valid;
  logic [4:0]  pc;
  logic        running;
  logic        done;
  logic        timeout;
  logic [3:0]  rID;
  logic        dump_valid;
  logic [15:0] cycles;
  logic        load_err;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] prog [32];
  logic [31:0] wd   [32];
  logic [31:0] last_instr;

  pro_runctl #(
    .DATA_W(32), .ADDR_W(5), .NREG(8), .ID_W(4), .HALT_ICODE(4'h0),
    .DRAIN_CYC(4), .MAX_CYCLES(40)
  ) dut (
    .clock(clock), .resetn(resetn), .addr(addr), .wr(wr), .wdata(wdata),
    .working(working), .stall(stall), .instr(instr), .instr_valid(instr_valid),
    .pc(pc), .running(running), .done(done), .timeout(timeout), .rID(rID),
    .dump_valid(dump_valid), .cycles(cycles), .load_err(load_err)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_word(input int a, input logic [31:0] d);
    addr  = 5'(a);
    wdata = d;
    wr    = 1'b1;
    tick();
    wr    = 1'b0;
  endtask

  // From the cycle after halt/timeout issue: 4 drain cycles, 8 dump IDs, DONE.
  task automatic drain_dump_done(input logic exp_to);
    for (int d = 0; d < 4; d++) begin
      tick();
      chk("drain_valid", 32'(instr_valid), 32'd0);
      chk("drain_running", 32'(running), 32'd1);
      chk("drain_dump_valid", 32'(dump_valid), 32'd0);
    end
    for (int r = 0; r < 8; r++) begin
      tick();
      chk("dump_rid", 32'(rID), 32'(r));
      chk("dump_valid", 32'(dump_valid), 32'd1);
      chk("dump_running", 32'(running), 32'd0);
      chk("dump_done", 32'(done), 32'd0);
    end
    tick();
    chk("done_flag", 32'(done), 32'd1);
    chk("done_rid", 32'(rID), 32'hF);
    chk("done_dump_valid", 32'(dump_valid), 32'd0);
    chk("done_timeout", 32'(timeout), 32'(exp_to));
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      if (i == 0)       prog[i] = 32'h10F00080;
      else if (i == 17) prog[i] = 32'h23670000;
      else if (i < 18)  prog[i] = 32'h30000000 | 32'(i << 12) | 32'(i);
      else              prog[i] = 32'h0;
      wd[i] = 32'h50000000 | 32'(i);
    end

    resetn = 1'b0; addr = '0; wr = 1'b0; wdata = '0; working = 1'b0; stall = 1'b0;
    tick();
    tick();
    chk("rst_instr", instr, 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_running", 32'(running), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    chk("rst_rid", 32'(rID), 32'hF);
    chk("rst_dump_valid", 32'(dump_valid), 32'd0);
    chk("rst_cycles", 32'(cycles), 32'd0);
    chk("rst_load_err", 32'(load_err), 32'd0);
    resetn = 1'b1;
    tick();

    // Load 18-word program, rest zero (halt).
    for (int i = 0; i < 32; i++) load_word(i, prog[i]);
    chk("idle_wr_no_err", 32'(load_err), 32'd0);

    // Run 1: halt at mem[18].
    working = 1'b1;
    tick();
    chk("r1_entry_running", 32'(running), 32'd1);
    chk("r1_entry_valid", 32'(instr_valid), 32'd0);
    chk("r1_entry_pc", 32'(pc), 32'd0);
    chk("r1_entry_cycles", 32'(cycles), 32'd0);
    for (int k = 0; k < 19; k++) begin
      tick();
      chk("r1_valid", 32'(instr_valid), 32'd1);
      chk("r1_instr", instr, prog[k]);
      chk("r1_pc", 32'(pc), 32'(k + 1));
    end
    chk("r1_cycles", 32'(cycles), 32'd19);
    drain_dump_done(1'b0);
    chk("r1_cycles_held", 32'(cycles), 32'd19);
    last_instr = prog[18];
    working = 1'b0;
    tick();
    chk("r1_idle_done_held", 32'(done), 32'd1);
    chk("r1_idle_running", 32'(running), 32'd0);

    // Run 2: alternate stall, rejected write, then abort.
    working = 1'b1;
    tick();
    chk("r2_entry_done_clr", 32'(done), 32'd0);
    for (int e = 1; e <= 8; e++) begin
      stall = (e % 2 == 1);
      if (e == 1) begin
        addr = 5'd2; wdata = 32'hDEADBEEF; wr = 1'b1;
      end
      tick();
      wr = 1'b0;
      if (e == 1) chk("r2_load_err_pulse", 32'(load_err), 32'd1);
      if (e == 2) chk("r2_load_err_clear", 32'(load_err), 32'd0);
      if (e % 2 == 1) begin
        chk("r2_stall_valid", 32'(instr_valid), 32'd0);
        chk("r2_stall_instr", instr, last_instr);
      end else begin
        last_instr = prog[e / 2 - 1];
        chk("r2_valid", 32'(instr_valid), 32'd1);
        chk("r2_instr", instr, last_instr);
        chk("r2_pc", 32'(pc), 32'(e / 2));
      end
    end
    stall = 1'b0;
    working = 1'b0;
    tick();
    chk("abort_running", 32'(running), 32'd0);
    chk("abort_valid", 32'(instr_valid), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    tick();
    chk("abort_no_dump", 32'(dump_valid), 32'd0);
    chk("abort_rid", 32'(rID), 32'hF);

    // Run 3: no halt word, watchdog ends run after wrapping pc.
    for (int i = 0; i < 32; i++) load_word(i, wd[i]);
    working = 1'b1;
    tick();
    chk("r3_entry_timeout", 32'(timeout), 32'd0);
    for (int k = 1; k <= 39; k++) begin
      tick();
      chk("r3_valid", 32'(instr_valid), 32'd1);
      chk("r3_instr", instr, wd[(k - 1) % 32]);
      chk("r3_pc", 32'(pc), 32'(k % 32));
      chk("r3_timeout", 32'(timeout), 32'(k == 39));
    end
    chk("r3_cycles", 32'(cycles), 32'd39);
    chk("r3_running", 32'(running), 32'd1);
    drain_dump_done(1'b1);
    working = 1'b0;
    tick();
    chk("r3_idle_timeout_held", 32'(timeout), 32'd1);

    // Run 4: halt fetched on the watchdog edge.
    wd[5] = 32'h0;
    load_word(5, wd[5]);
    working = 1'b1;
    stall = 1'b1;
    tick();
    chk("r4_entry_timeout", 32'(timeout), 32'd0);
    chk("r4_entry_done", 32'(done), 32'd0);
    repeat (33) tick();
    chk("r4_stall_cycles", 32'(cycles), 32'd33);
    chk("r4_stall_pc", 32'(pc), 32'd0);
    chk("r4_stall_valid", 32'(instr_valid), 32'd0);
    stall = 1'b0;
    for (int j = 0; j < 6; j++) begin
      tick();
      chk("r4_instr", instr, wd[j]);
      chk("r4_valid", 32'(instr_valid), 32'd1);
    end
    chk("r4_cycles", 32'(cycles), 32'd39);
    chk("r4_timeout", 32'(timeout), 32'd0);
    drain_dump_done(1'b0);
    working = 1'b0;
    tick();

    // Run 5: reset mid-dump, memory preserved.
    working = 1'b1;
    tick();
    repeat (6) tick();
    repeat (4) tick();
    repeat (3) tick();
    chk("r5_mid_dump_rid", 32'(rID), 32'd2);
    chk("r5_mid_dump_valid", 32'(dump_valid), 32'd1);
    working = 1'b0;
    resetn = 1'b0;
    #1;
    chk("r5_rst_rid", 32'(rID), 32'hF);
    chk("r5_rst_dump_valid", 32'(dump_valid), 32'd0);
    chk("r5_rst_running", 32'(running), 32'd0);
    chk("r5_rst_pc", 32'(pc), 32'd0);
    chk("r5_rst_instr", instr, 32'd0);
    chk("r5_rst_cycles", 32'(cycles), 32'd0);
    resetn = 1'b1;
    working = 1'b1;
    tick();
    tick();
    chk("r5_mem_kept_instr", instr, wd[0]);
    chk("r5_mem_kept_valid", 32'(instr_valid), 32'd1);
    working = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
